// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-ported data memory.
// Each access walks IDLE -> ACCESS -> RESP; illegal addresses never assert mem_we.
module dmem_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ready0,
  output logic          ready1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic we;
    logic ill;
    logic gnt;
  } lat_req_t;

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH * 4);

  state_t   state;
  logic     prio;
  lat_req_t cur;

  logic          sel;
  logic          sel_we;
  logic          sel_ill;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rd_ok;

  always_comb begin
    // A lone requester wins outright; a tie goes to the priority pointer.
    sel       = (req0 & req1) ? prio : req1;
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    sel_ill   = (sel_addr[1:0] != 2'b00) || (sel_addr >= LIMIT);
    rd_ok     = ~cur.we & ~cur.ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cur       <= '0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ready0    <= 1'b0;
      ready1    <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            prio      <= ~sel;
            cur       <= '{we: sel_we, ill: sel_ill, gnt: sel};
            mem_we    <= sel_we & ~sel_ill;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          // Write commits at this edge; read data is captured from the array now.
          state     <= RESP;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          ready0    <= ~cur.gnt;
          ready1    <= cur.gnt;
          err0      <= ~cur.gnt & cur.ill;
          err1      <= cur.gnt & cur.ill;
          rdata0    <= (~cur.gnt & rd_ok) ? mem_rdata : '0;
          rdata1    <= (cur.gnt & rd_ok) ? mem_rdata : '0;
        end
        RESP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ready0 <= 1'b0;
          ready1 <= 1'b0;
          err0   <= 1'b0;
          err1   <= 1'b0;
          rdata0 <= '0;
          rdata1 <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 16-word DataMemory attached.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ready0, ready1, err0, err1, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        tb_init = 1'b0;
  logic [31:0] mem [16];
  int          vecs = 0, errs = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(16), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // DataMemory model: synchronous write, combinational read, preset to 0x1000_0000+i.
  always @(posedge clk) begin
    if (!tb_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (mem_we && mem_addr < 32'd64) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:2]] : 32'hBAD0_BAD0;

  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat, output logic saw_we);
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    lat = -1; rd = '0; er = 1'b0; saw_we = 1'b0;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(posedge clk); @(negedge clk);
      saw_we = saw_we | mem_we;
      if (p == 0 && ready0) begin lat = c; rd = rdata0; er = err0; end
      if (p == 1 && ready1) begin lat = c; rd = rdata1; er = err1; end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, sw; int lat;
    repeat (3) @(posedge clk);
    tb_init = 1'b1;
    @(negedge clk);
    vecs++;
    if ({ready0, ready1, err0, err1, mem_we, busy} !== 6'b0)
      begin errs++; $display("FAIL reset_ctrl got %b want 000000", {ready0, ready1, err0, err1, mem_we, busy}); end
    vecs++;
    if ({rdata0, rdata1, mem_addr, mem_wdata} !== 128'b0)
      begin errs++; $display("FAIL reset_data got %h want 0", {rdata0, rdata1, mem_addr, mem_wdata}); end
    rst_n = 1;
    // Reset landing in ACCESS of a write to 0x8.
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h8; wdata0 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    vecs++;
    if ({mem_we, busy, mem_addr} !== {2'b11, 32'h8})
      begin errs++; $display("FAIL access_state got we=%b busy=%b addr=%h want 1 1 8", mem_we, busy, mem_addr); end
    #2 rst_n = 0; #1;
    vecs++;
    if ({mem_we, busy, mem_addr, mem_wdata} !== 66'b0)
      begin errs++; $display("FAIL reset_abort got we=%b busy=%b addr=%h wd=%h want 0", mem_we, busy, mem_addr, mem_wdata); end
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    @(posedge clk); @(negedge clk);
    vecs++;
    if (ready0 !== 1'b0) begin errs++; $display("FAIL reset_no_ready got %b want 0", ready0); end
    vecs++;
    if (mem[2] !== 32'h1000_0002) begin errs++; $display("FAIL reset_no_write got %h want 10000002", mem[2]); end
    rst_n = 1;
    txn(0, 1'b0, 32'h8, 32'h0, rd, er, lat, sw);
    vecs++;
    if (rd !== 32'h1000_0002 || lat != 2)
      begin errs++; $display("FAIL reset_readback got %h lat %0d want 10000002 lat 2", rd, lat); end
  endtask

  task automatic test_single();
    logic [31:0] rd; logic er, sw; int lat;
    txn(0, 1'b1, 32'h0, 32'hA5A5_A5A5, rd, er, lat, sw);
    vecs++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0 || sw !== 1'b1)
      begin errs++; $display("FAIL single_write got lat=%0d err=%b rd=%h we=%b want 2 0 0 1", lat, er, rd, sw); end
    txn(0, 1'b0, 32'h0, 32'h0, rd, er, lat, sw);
    vecs++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'hA5A5_A5A5)
      begin errs++; $display("FAIL single_read got lat=%0d err=%b rd=%h want 2 0 a5a5a5a5", lat, er, rd); end
  endtask

  task automatic test_contention();
    int t0a = -1, t0b = -1, t1 = -1, n0 = 0, ov = 0;
    logic [31:0] r0 = '0, r1 = '0;
    logic upd0 = 0, upd1 = 0;
    do_reset();
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h4; wdata0 = 32'h5A5A_5A5A;
    req1 = 1; we1 = 0; addr1 = 32'h4; wdata1 = 32'h0;
    for (int c = 1; c <= 20 && (t0b < 0 || t1 < 0); c++) begin
      @(posedge clk); #1;
      // Port 0 follows its write with a read while port 1 is still waiting.
      if (upd0) begin upd0 = 0; if (n0 == 1) begin we0 = 0; wdata0 = 0; end else req0 = 0; end
      if (upd1) begin upd1 = 0; req1 = 0; end
      @(negedge clk);
      if (ready0 && ready1) ov++;
      if (ready0) begin n0++; upd0 = 1; if (n0 == 1) t0a = c; else begin t0b = c; r0 = rdata0; end end
      if (ready1) begin t1 = c; r1 = rdata1; upd1 = 1; end
    end
    @(posedge clk); #1; req0 = 0; req1 = 0;
    vecs++;
    if (t0a != 2) begin errs++; $display("FAIL cont_first0 got cycle %0d want 2", t0a); end
    vecs++;
    if (t1 != 5 || r1 !== 32'h5A5A_5A5A)
      begin errs++; $display("FAIL cont_port1 got cycle %0d rd %h want 5 5a5a5a5a", t1, r1); end
    vecs++;
    if (t0b != 8 || r0 !== 32'h5A5A_5A5A)
      begin errs++; $display("FAIL cont_second0 got cycle %0d rd %h want 8 5a5a5a5a", t0b, r0); end
    vecs++;
    if (ov != 0) begin errs++; $display("FAIL cont_overlap got %0d want 0", ov); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er, sw; int lat;
    txn(1, 1'b0, 32'h40, 32'h0, rd, er, lat, sw);
    vecs++;
    if (lat != 2 || er !== 1'b1 || rd !== 32'h0 || sw !== 1'b0)
      begin errs++; $display("FAIL ill_range got lat=%0d err=%b rd=%h we=%b want 2 1 0 0", lat, er, rd, sw); end
    txn(1, 1'b1, 32'h6, 32'h1234_5678, rd, er, lat, sw);
    vecs++;
    if (lat != 2 || er !== 1'b1 || rd !== 32'h0 || sw !== 1'b0)
      begin errs++; $display("FAIL ill_align got lat=%0d err=%b rd=%h we=%b want 2 1 0 0", lat, er, rd, sw); end
    txn(1, 1'b0, 32'h4, 32'h0, rd, er, lat, sw);
    vecs++;
    if (er !== 1'b0 || rd !== 32'h5A5A_5A5A)
      begin errs++; $display("FAIL ill_unchanged got err=%b rd=%h want 0 5a5a5a5a", er, rd); end
  endtask

  task automatic test_back_to_back();
    int k0 = 0, k1 = 0, n = 0, ov = 0, p;
    logic upd0 = 0, upd1 = 0;
    logic [31:0] exp;
    do_reset();
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h0; wdata0 = 32'hF000_0000;
    req1 = 1; we1 = 0; addr1 = 32'h0; wdata1 = 32'h0;
    for (int c = 1; c <= 60 && n < 12; c++) begin
      @(posedge clk); #1;
      if (upd0) begin
        upd0 = 0; k0++;
        if (k0 < 6) begin addr0 = 32'(k0 * 4); wdata0 = 32'hF000_0000 + 32'(k0); end else req0 = 0;
      end
      if (upd1) begin
        upd1 = 0; k1++;
        if (k1 < 6) addr1 = 32'(k1 * 4); else req1 = 0;
      end
      @(negedge clk);
      if (ready0 && ready1) ov++;
      if (ready0 || ready1) begin
        p = ready1 ? 1 : 0;
        vecs++;
        if (p != n % 2) begin errs++; $display("FAIL b2b_order txn %0d got port %0d want %0d", n, p, n % 2); end
        vecs++;
        if (c != 2 + 3 * n) begin errs++; $display("FAIL b2b_spacing txn %0d got cycle %0d want %0d", n, c, 2 + 3 * n); end
        if (ready1) begin
          exp = 32'hF000_0000 + 32'(k1);
          vecs++;
          if (rdata1 !== exp) begin errs++; $display("FAIL b2b_rdata txn %0d got %h want %h", n, rdata1, exp); end
        end
        upd0 = ready0; upd1 = ready1; n++;
      end
    end
    @(posedge clk); #1; req0 = 0; req1 = 0;
    vecs++;
    if (n != 12) begin errs++; $display("FAIL b2b_count got %0d want 12", n); end
    vecs++;
    if (ov != 0) begin errs++; $display("FAIL b2b_overlap got %0d want 0", ov); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
